// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller:
// hazard-detection inputs, stage enables/flushes and performance counters.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1_addr;
    logic [4:0]       id_rs2_addr;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             id_ex_mem_read;
    logic [4:0]       id_ex_rd_addr;
    logic             ex_branch_taken;
    logic             ex_mem_mem_access;
    logic             dmem_ready;
    logic             perf_clr;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic [CNT_W-1:0] stall_cycles;
    logic [15:0]      flush_count;
    logic             mem_timeout_err;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
               id_ex_mem_read, id_ex_rd_addr, ex_branch_taken,
               ex_mem_mem_access, dmem_ready, perf_clr,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
               stall_cycles, flush_count, mem_timeout_err
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
               id_ex_mem_read, id_ex_rd_addr, ex_branch_taken,
               ex_mem_mem_access, dmem_ready, perf_clr,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
               stall_cycles, flush_count, mem_timeout_err
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory stalls, branch flushes and
// load-use bubbles, with stall/flush performance counters and a sticky memory timeout.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 256,
    parameter int          CNT_W       = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [15:0] TIMEOUT_C = 16'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [15:0]      flush_q, flush_d;
    logic [15:0]      wait_q, wait_d;
    logic             err_q, err_d;

    logic load_use_s;
    logic pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s;
    logic if_id_flush_s, id_ex_flush_s;

    // Load-use: EX holds a load whose nonzero destination the ID instruction reads.
    always_comb begin
        load_use_s = hz.id_ex_mem_read && (hz.id_ex_rd_addr != 5'd0) &&
                     ((hz.id_uses_rs1 && (hz.id_rs1_addr == hz.id_ex_rd_addr)) ||
                      (hz.id_uses_rs2 && (hz.id_rs2_addr == hz.id_ex_rd_addr)));
    end

    // Next state and stage controls; memory stall outranks branch, branch outranks load-use.
    always_comb begin
        state_d       = state_q;
        pc_en_s       = 1'b1;
        if_id_en_s    = 1'b1;
        id_ex_en_s    = 1'b1;
        ex_mem_en_s   = 1'b1;
        if_id_flush_s = 1'b0;
        id_ex_flush_s = 1'b0;
        case (state_q)
            RUN, MEM_WAIT: begin
                if (!hz.dmem_ready && (state_q == MEM_WAIT || hz.ex_mem_mem_access)) begin
                    pc_en_s     = 1'b0;
                    if_id_en_s  = 1'b0;
                    id_ex_en_s  = 1'b0;
                    ex_mem_en_s = 1'b0;
                    state_d     = MEM_WAIT;
                end else if (hz.ex_branch_taken) begin
                    if_id_flush_s = 1'b1;
                    id_ex_flush_s = 1'b1;
                    state_d       = RUN;
                end else if (load_use_s) begin
                    pc_en_s       = 1'b0;
                    if_id_en_s    = 1'b0;
                    id_ex_flush_s = 1'b1;
                    state_d       = RUN;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                pc_en_s       = 1'b0;
                if_id_en_s    = 1'b0;
                id_ex_en_s    = 1'b0;
                ex_mem_en_s   = 1'b0;
                if_id_flush_s = 1'b1;
                id_ex_flush_s = 1'b1;
                state_d       = RUN;
            end
        endcase
    end

    // Saturating counters and timeout tracking; perf_clr wins over any same-cycle update.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        wait_d  = wait_q;
        err_d   = err_q;
        if (state_q == RUN || state_q == MEM_WAIT) begin
            if (!pc_en_s && (stall_q != {CNT_W{1'b1}})) begin
                stall_d = stall_q + CNT_W'(1);
            end else begin
                stall_d = stall_q;
            end
            if (id_ex_flush_s && (flush_q != 16'hFFFF)) begin
                flush_d = flush_q + 16'd1;
            end else begin
                flush_d = flush_q;
            end
        end else begin
            stall_d = stall_q;
            flush_d = flush_q;
        end
        if (state_q == MEM_WAIT && !hz.dmem_ready) begin
            if (wait_q < TIMEOUT_C) begin
                wait_d = wait_q + 16'd1;
            end else begin
                wait_d = wait_q;
            end
            if (wait_d >= TIMEOUT_C) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
        end else begin
            wait_d = 16'd0;
        end
        if (hz.perf_clr) begin
            stall_d = '0;
            flush_d = 16'd0;
            err_d   = 1'b0;
        end else begin
            err_d = err_d;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            stall_q <= '0;
            flush_q <= 16'd0;
            wait_q  <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    assign hz.pc_en           = pc_en_s;
    assign hz.if_id_en        = if_id_en_s;
    assign hz.id_ex_en        = id_ex_en_s;
    assign hz.ex_mem_en       = ex_mem_en_s;
    assign hz.if_id_flush     = if_id_flush_s;
    assign hz.id_ex_flush     = id_ex_flush_s;
    assign hz.stall_cycles    = stall_q;
    assign hz.flush_count     = flush_q;
    assign hz.mem_timeout_err = err_q;
endmodule
